// File: rtl/mem_pkg.sv
// Shared memory-access definitions: size codes, response payload and the
// alignment rule used by the data-side error check.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SZ_W   = 2;

    typedef logic [SZ_W-1:0] size_t;

    localparam size_t SZ_NONE = 2'b00;
    localparam size_t SZ_BYTE = 2'b01;
    localparam size_t SZ_HALF = 2'b10;
    localparam size_t SZ_WORD = 2'b11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } resp_t;

    // True when an access of size sz cannot start at byte offset lsb.
    function automatic logic misaligned(input size_t sz, input logic [1:0] lsb);
        case (sz)
            SZ_HALF: return lsb[0];
            SZ_WORD: return lsb != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/resp_slot.sv
// One-entry response buffer; holds a response until the consumer accepts it.
module resp_slot
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  resp_t             load_resp,
    input  logic              rready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              free_c
);

    // A slot can accept a new response when empty or being drained this cycle.
    assign free_c = ~rvalid | rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else if (load) begin
            rvalid <= 1'b1;
            rdata  <= load_resp.data;
            err    <= load_resp.err;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) onto a single
// memory port, with data priority bounded by an instruction anti-starvation count.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_MSB     = 15,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              i_rready,

    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic [1:0]        d_write_en,
    input  logic [1:0]        d_read_en,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    input  logic              d_rready,

    output logic [31:0]       m_addr,
    output logic [1:0]        m_write_en,
    output logic [1:0]        m_read_en,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << (ADDR_MSB + 1)) - 64'd1);
    localparam logic [31:0] WORD_MASK = ~32'd3;

    logic             i_free_c;
    logic             d_free_c;
    logic             i_elig_c;
    logic             d_elig_c;
    size_t            d_size_c;
    logic             d_bad_c;
    resp_t            i_resp_c;
    resp_t            d_resp_c;
    logic [CNT_W-1:0] starve_cnt;

    assign i_elig_c = i_req & i_free_c;
    assign d_elig_c = d_req & d_free_c;

    // Malformed data requests still get a grant but never touch memory.
    assign d_size_c = d_write_en | d_read_en;
    assign d_bad_c  = ((d_write_en != SZ_NONE) == (d_read_en != SZ_NONE))
                    | misaligned(d_size_c, d_addr[1:0]);

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_elig_c && d_elig_c) begin
                if (starve_cnt == CNT_MAX) i_gnt = 1'b1;
                else                       d_gnt = 1'b1;
            end else begin
                i_gnt = i_elig_c;
                d_gnt = d_elig_c;
            end
        end
    end

    always_comb begin
        m_addr     = '0;
        m_write_en = SZ_NONE;
        m_read_en  = SZ_NONE;
        m_wdata    = '0;
        if (i_gnt) begin
            m_addr    = i_addr & ADDR_MASK & WORD_MASK;
            m_read_en = SZ_WORD;
        end else if (d_gnt) begin
            m_addr = d_addr & ADDR_MASK;
            if (!d_bad_c) begin
                m_write_en = d_write_en;
                m_read_en  = d_read_en;
                if (d_write_en != SZ_NONE) m_wdata = d_wdata;
            end
        end
    end

    always_comb begin
        i_resp_c = '{data: m_rdata, err: 1'b0};
        d_resp_c = '{data: m_rdata, err: 1'b0};
        if (d_bad_c)                       d_resp_c = '{data: '0, err: 1'b1};
        else if (d_write_en != SZ_NONE)    d_resp_c = '{data: '0, err: 1'b0};
    end

    // Counts data wins taken while a fetch was also waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && i_elig_c && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    resp_slot u_i_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (i_gnt),
        .load_resp (i_resp_c),
        .rready    (i_rready),
        .rvalid    (i_rvalid),
        .rdata     (i_rdata),
        .err       (),
        .free_c    (i_free_c)
    );

    resp_slot u_d_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (d_gnt),
        .load_resp (d_resp_c),
        .rready    (d_rready),
        .rvalid    (d_rvalid),
        .rdata     (d_rdata),
        .err       (d_err),
        .free_c    (d_free_c)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int STARVE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid, i_rready;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_gnt, d_rvalid, d_err, d_rready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_write_en, d_read_en;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_write_en, m_read_en;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_MSB(15), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_rready(i_rready),
        .d_req(d_req), .d_addr(d_addr), .d_write_en(d_write_en), .d_read_en(d_read_en),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err), .d_rready(d_rready),
        .m_addr(m_addr), .m_write_en(m_write_en), .m_read_en(m_read_en),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Behavioural memory: combinational read, byte-lane write at posedge.
    assign m_rdata = mem[m_addr[9:2]];

    always @(posedge clk) begin : memw
        logic [31:0] w;
        w = mem[m_addr[9:2]];
        case (m_write_en)
            2'b11: w = m_wdata;
            2'b10: if (m_addr[1]) w[31:16] = m_wdata[15:0]; else w[15:0] = m_wdata[15:0];
            2'b01: w[8*m_addr[1:0] +: 8] = m_wdata[7:0];
            default: ;
        endcase
        if (m_write_en != 2'b00) mem[m_addr[9:2]] <= w;
    end

    // Error rule: exactly one direction enabled, and address a multiple of the size.
    function automatic bit req_err(input logic [1:0] we, input logic [1:0] re, input logic [31:0] a);
        logic [1:0] sz;
        int nbytes;
        if ((we != 2'b00) == (re != 2'b00)) return 1'b1;
        sz = (we != 2'b00) ? we : re;
        nbytes = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
        return (int'(a) % nbytes) != 0;
    endfunction

    task automatic idle_inputs();
        i_req = 0; i_addr = 0; i_rready = 1;
        d_req = 0; d_addr = 0; d_write_en = 0; d_read_en = 0; d_wdata = 0; d_rready = 1;
    endtask

    task automatic quiesce();
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_req = 1; d_req = 1; d_read_en = 2'b11; rst = 1;
        @(negedge clk);
        total_cnt++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {i_gnt, d_gnt, i_rvalid, d_rvalid, d_err});
        else pass_cnt++;
        total_cnt++;
        if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata});
        else pass_cnt++;
        total_cnt++;
        if ({m_write_en, m_read_en} !== 4'b0) $display("FAIL reset_m_en: got %b expected 0000", {m_write_en, m_read_en});
        else pass_cnt++;
        @(posedge clk); #1;
        idle_inputs();
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_write_en, m_read_en} !== 8'b0)
                $display("FAIL idle_c%0d: got %b expected 00000000", c, {i_gnt, d_gnt, i_rvalid, d_rvalid, m_write_en, m_read_en});
            else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        logic [1:0] order [6];
        order = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        idle_inputs();
        i_req = 1; i_addr = 32'h40;
        d_req = 1; d_addr = 32'h80; d_read_en = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({i_gnt, d_gnt} !== order[k]) $display("FAIL starve_order_%0d: got %b expected %b", k, {i_gnt, d_gnt}, order[k]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        quiesce();
    endtask

    task automatic test_store_load();
        idle_inputs();
        d_req = 1; d_addr = 32'h100; d_write_en = 2'b11; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total_cnt++;
        if ({d_gnt, m_write_en, m_read_en, m_addr, m_wdata} !== {1'b1, 2'b11, 2'b00, 32'h100, 32'hDEADBEEF})
            $display("FAIL store_grant: got %b %b %b %h %h expected 1 11 00 00000100 deadbeef", d_gnt, m_write_en, m_read_en, m_addr, m_wdata);
        else pass_cnt++;
        @(posedge clk); #1;
        d_write_en = 2'b00; d_read_en = 2'b11; d_wdata = 0;
        @(negedge clk);
        total_cnt++;
        if ({d_rvalid, d_rdata, d_err} !== {1'b1, 32'h0, 1'b0}) $display("FAIL store_resp: got %b %h %b expected 1 00000000 0", d_rvalid, d_rdata, d_err);
        else pass_cnt++;
        total_cnt++;
        if ({d_gnt, m_read_en} !== 3'b111) $display("FAIL load_grant: got %b expected 111", {d_gnt, m_read_en});
        else pass_cnt++;
        @(posedge clk); #1;
        d_req = 0;
        @(negedge clk);
        total_cnt++;
        if ({d_rvalid, d_rdata, d_err} !== {1'b1, 32'hDEADBEEF, 1'b0}) $display("FAIL load_resp: got %b %h %b expected 1 deadbeef 0", d_rvalid, d_rdata, d_err);
        else pass_cnt++;
        quiesce();
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3];
        logic [3:0]  ctl [3];
        addrs = '{32'h101, 32'h102, 32'h104};
        ctl   = '{4'b0010, 4'b0011, 4'b1111};
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            d_req = 1; d_addr = addrs[k]; d_write_en = ctl[k][3:2]; d_read_en = ctl[k][1:0]; d_wdata = 32'h12345678;
            @(negedge clk);
            total_cnt++;
            if ({d_gnt, m_write_en, m_read_en} !== 5'b10000) $display("FAIL err_grant_%0d: got %b expected 10000", k, {d_gnt, m_write_en, m_read_en});
            else pass_cnt++;
            @(posedge clk); #1;
            d_req = 0;
            @(negedge clk);
            total_cnt++;
            if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) $display("FAIL err_resp_%0d: got %b %b %h expected 1 1 00000000", k, d_rvalid, d_err, d_rdata);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        quiesce();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_i;
        idle_inputs();
        i_req = 1; i_addr = 32'h21; i_rready = 0;
        @(negedge clk);
        exp_i = mem[8];
        total_cnt++;
        if (i_gnt !== 1'b1) $display("FAIL bp_first_gnt: got %b expected 1", i_gnt);
        else pass_cnt++;
        @(posedge clk); #1;
        d_req = 1; d_addr = 32'h40; d_read_en = 2'b11;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({i_gnt, d_gnt, i_rvalid} !== 3'b011) $display("FAIL bp_hold_gnt_%0d: got %b expected 011", c, {i_gnt, d_gnt, i_rvalid});
            else pass_cnt++;
            total_cnt++;
            if (i_rdata !== exp_i) $display("FAIL bp_rdata_%0d: got %h expected %h", c, i_rdata, exp_i);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        d_req = 0; i_rready = 1;
        @(negedge clk);
        total_cnt++;
        if (i_gnt !== 1'b1) $display("FAIL bp_release_gnt: got %b expected 1", i_gnt);
        else pass_cnt++;
        quiesce();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        d_req = 1; d_addr = 32'h44; d_read_en = 2'b11; d_rready = 0;
        @(posedge clk); #1;
        d_req = 0;
        total_cnt++;
        if (d_rvalid !== 1'b1) $display("FAIL rstmid_pending: got %b expected 1", d_rvalid);
        else pass_cnt++;
        i_req = 1; d_req = 1; d_write_en = 2'b11; d_read_en = 2'b00; rst = 1;
        #1;
        total_cnt++;
        if ({d_rvalid, d_err, i_gnt, d_gnt} !== 4'b0) $display("FAIL rstmid_drop: got %b expected 0000", {d_rvalid, d_err, i_gnt, d_gnt});
        else pass_cnt++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({i_gnt, d_gnt, m_write_en, m_read_en, d_rvalid} !== 7'b0) $display("FAIL rstmid_hold_%0d: got %b expected 0000000", c, {i_gnt, d_gnt, m_write_en, m_read_en, d_rvalid});
            else pass_cnt++;
        end
        @(posedge clk); #1;
        idle_inputs();
        rst = 0;
        quiesce();
    endtask

    task automatic test_random();
        bit          mi_v, md_v, md_e, i_el, d_el, exp_i, exp_d, last_i, last_d, err;
        logic [31:0] mi_d, md_d;
        int          starve, k;
        logic [1:0]  sz;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        mi_v = 0; md_v = 0; md_e = 0; mi_d = 0; md_d = 0; starve = 0;
        last_i = 1; last_d = 1;
        for (int c = 0; c < 400; c++) begin
            if (!(i_req && !last_i && $urandom_range(0, 7) != 0)) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'($urandom_range(0, 1023));
            end
            if (!(d_req && !last_d && $urandom_range(0, 7) != 0)) begin
                d_req = ($urandom_range(0, 2) != 0);
                k = $urandom_range(0, 9);
                sz = 2'($urandom_range(1, 3));
                if (k < 5)       begin d_read_en = sz; d_write_en = 0; end
                else if (k < 8)  begin d_write_en = sz; d_read_en = 0; end
                else if (k == 8) begin d_write_en = sz; d_read_en = sz; end
                else             begin d_write_en = 0; d_read_en = 0; end
                d_addr = (32'($urandom_range(0, 255)) << 2)
                       | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
                d_wdata = $urandom;
            end
            i_rready = ($urandom_range(0, 3) != 0);
            d_rready = ($urandom_range(0, 3) != 0);

            @(negedge clk);
            i_el  = i_req && (!mi_v || i_rready);
            d_el  = d_req && (!md_v || d_rready);
            exp_i = i_el && (!d_el || starve == STARVE);
            exp_d = d_el && !exp_i;
            err   = req_err(d_write_en, d_read_en, d_addr);

            total_cnt++;
            if ({i_gnt, d_gnt} !== {exp_i, exp_d}) $display("FAIL rnd_gnt_c%0d: got %b expected %b", c, {i_gnt, d_gnt}, {exp_i, exp_d});
            else pass_cnt++;
            total_cnt++;
            if ({i_rvalid, d_rvalid} !== {mi_v, md_v}) $display("FAIL rnd_rvalid_c%0d: got %b expected %b", c, {i_rvalid, d_rvalid}, {mi_v, md_v});
            else pass_cnt++;
            if (mi_v) begin
                total_cnt++;
                if (i_rdata !== mi_d) $display("FAIL rnd_i_rdata_c%0d: got %h expected %h", c, i_rdata, mi_d);
                else pass_cnt++;
            end
            if (md_v) begin
                total_cnt++;
                if ({d_rdata, d_err} !== {md_d, md_e}) $display("FAIL rnd_d_resp_c%0d: got %h %b expected %h %b", c, d_rdata, d_err, md_d, md_e);
                else pass_cnt++;
            end
            if (exp_i) begin
                total_cnt++;
                if ({m_addr, m_write_en, m_read_en} !== {i_addr & ~32'd3, 4'b0011})
                    $display("FAIL rnd_m_fetch_c%0d: got %h %b %b expected %h 00 11", c, m_addr, m_write_en, m_read_en, i_addr & ~32'd3);
                else pass_cnt++;
            end else if (exp_d) begin
                total_cnt++;
                if ({m_addr, m_write_en, m_read_en} !== {d_addr, err ? 4'b0 : {d_write_en, d_read_en}})
                    $display("FAIL rnd_m_data_c%0d: got %h %b %b expected %h err=%0d", c, m_addr, m_write_en, m_read_en, d_addr, err);
                else pass_cnt++;
            end else begin
                total_cnt++;
                if ({m_write_en, m_read_en} !== 4'b0) $display("FAIL rnd_m_idle_c%0d: got %b expected 0000", c, {m_write_en, m_read_en});
                else pass_cnt++;
            end

            if (mi_v && i_rready) mi_v = 0;
            if (md_v && d_rready) md_v = 0;
            if (exp_i) begin mi_v = 1; mi_d = mem[i_addr[9:2]]; end
            if (exp_d) begin
                md_v = 1;
                if (err)                     begin md_d = 0; md_e = 1; end
                else if (d_write_en != 2'b00) begin md_d = 0; md_e = 0; end
                else                         begin md_d = mem[d_addr[9:2]]; md_e = 0; end
            end
            if (exp_i) starve = 0;
            else if (exp_d && i_el && starve < STARVE) starve++;
            last_i = exp_i;
            last_d = exp_d;

            @(posedge clk); #1;
        end
        quiesce();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        rst = 1;
        idle_inputs();
        #1;
        test_reset();
        test_idle();
        test_starvation();
        test_store_load();
        test_misaligned();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_MSB, default 15, highest memory word-address bit forwarded downstream.
REQ-002 SHALL have parameter STARVE_LIMIT, default 2, max consecutive contested data grants before instruction wins.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_req in 1, i_addr in 32: instruction fetch request, word read only.
REQ-006 SHALL have ports i_gnt out 1, i_rvalid out 1, i_rdata out 32, i_rready in 1: fetch grant and response.
REQ-007 SHALL have ports d_req in 1, d_addr in 32, d_write_en in 2, d_read_en in 2, d_wdata in 32: data request; size code 11 word, 10 half, 01 byte, 00 none.
REQ-008 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out 32, d_err out 1, d_rready in 1: data grant and response.
REQ-009 SHALL have ports m_addr out 32, m_write_en out 2, m_read_en out 2, m_wdata out 32, m_rdata in 32: single shared memory port; memory writes at posedge, reads combinationally.

Function
REQ-010 Requester SHALL be eligible when req=1 and its response slot is empty or is being drained this cycle (rvalid&rready).
REQ-011 At most one of i_gnt, d_gnt SHALL be 1 per cycle; grant is combinational from eligibility and registered arbitration state.
REQ-012 Only one eligible: that requester SHALL be granted.
REQ-013 Both eligible: data SHALL win unless starve_cnt==STARVE_LIMIT, then instruction wins.
REQ-014 starve_cnt SHALL increment on a data grant while instruction is eligible, clear on any instruction grant, saturate at STARVE_LIMIT.
REQ-015 Granted cycle: m_* SHALL carry the winner's address/controls (instruction: m_read_en=11, m_write_en=00, m_wdata=0); no grant: m_write_en=m_read_en=00, m_addr=0, m_wdata=0.
REQ-016 On grant, m_rdata SHALL be captured into the winner's response slot at that posedge; rvalid=1 from the next cycle (1-cycle latency).
REQ-017 Response SHALL hold rvalid/rdata/err stable until rvalid&rready; slot then empties unless refilled the same edge.
REQ-018 Data write grant SHALL produce a response with d_rdata=0, d_err=0.
REQ-019 Data request SHALL be an error if: both d_write_en and d_read_en nonzero, both 00, half with d_addr[0]=1, or word with d_addr[1:0]!=00.
REQ-020 Error request SHALL still be granted, SHALL drive m_write_en=m_read_en=00, and SHALL respond d_err=1, d_rdata=0.
REQ-021 Requester SHALL hold req and payload stable until gnt; dropping req before gnt is legal and cancels.
REQ-022 Instruction fetch SHALL ignore i_addr[1:0] (no error path).

Reset
REQ-023 While rst=1: i_gnt, d_gnt, i_rvalid, d_rvalid, d_err = 0; i_rdata, d_rdata = 0; starve_cnt = 0; m_write_en, m_read_en = 00.
REQ-024 Reset mid-operation SHALL drop pending responses without a memory write.

Structure
REQ-025 Size codes SZ_NONE/SZ_BYTE/SZ_HALF/SZ_WORD and a misalignment function SHALL live in shared package mem_pkg.
REQ-026 One-entry response buffer SHALL be sub-module resp_slot, instantiated once per requester.

Verification
REQ-027 Idle: no req for 10 cycles -> m_write_en=m_read_en=00, no gnt, no rvalid.
REQ-028 Both req every cycle, STARVE_LIMIT=2, rready=1 -> grant order D,D,I,D,D,I.
REQ-029 Word store 0xDEADBEEF to 0x100, then word load 0x100 -> d_rvalid one cycle after grant, d_rdata=0xDEADBEEF, d_err=0.
REQ-030 Half load at 0x101 -> d_gnt=1, m_read_en=00, next cycle d_err=1, d_rdata=0.
REQ-031 i_rready=0 with fetch response pending, i_req=1 -> no further i_gnt, i_rdata stable, data still granted; i_rready=1 -> i_gnt same cycle.
REQ-032 rst asserted while d_rvalid=1 -> d_rvalid=0 immediately, no gnt until rst released.
